// File: rtl/match_peak_tracker_if.sv
// Pixel/score stream and per-frame result bundle between the adder tree side
// and the peak tracker.
interface match_peak_tracker_if #(
    parameter int SCORE_WIDTH = 13,
    parameter int X_WIDTH     = 10,
    parameter int Y_WIDTH     = 9
);
    logic                   pix_valid;
    logic                   sof;
    logic [SCORE_WIDTH-1:0] score;
    logic [SCORE_WIDTH-1:0] thresh;
    logic                   busy;
    logic                   res_valid;
    logic                   res_found;
    logic [X_WIDTH-1:0]     res_x;
    logic [Y_WIDTH-1:0]     res_y;
    logic [SCORE_WIDTH-1:0] res_score;

    modport master (
        output pix_valid, sof, score, thresh,
        input  busy, res_valid, res_found, res_x, res_y, res_score
    );

    modport slave (
        input  pix_valid, sof, score, thresh,
        output busy, res_valid, res_found, res_x, res_y, res_score
    );
endinterface

// File: rtl/match_peak_tracker.sv
// Re-aligns pixel coordinates to the delayed adder-tree score and reports the
// best full-window match position at or above threshold once per frame.
module match_peak_tracker #(
    parameter int TEMPL_SIZE   = 64,
    parameter int SCORE_WIDTH  = 13,
    parameter int TREE_LATENCY = 12,
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int X_WIDTH      = 10,
    parameter int Y_WIDTH      = 9
) (
    input  logic                 clk,
    input  logic                 nrst,
    match_peak_tracker_if.slave  bus
);
    localparam logic [X_WIDTH-1:0] X_LAST = X_WIDTH'(H_ACTIVE - 1);
    localparam logic [Y_WIDTH-1:0] Y_LAST = Y_WIDTH'(V_ACTIVE - 1);
    localparam logic [X_WIDTH-1:0] X_MIN  = X_WIDTH'(TEMPL_SIZE - 1);
    localparam logic [Y_WIDTH-1:0] Y_MIN  = Y_WIDTH'(TEMPL_SIZE - 1);

    typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

    state_t state, state_nxt;

    logic                   in_frame, accept, pix_last;
    logic [X_WIDTH-1:0]     cnt_x, pix_x;
    logic [Y_WIDTH-1:0]     cnt_y, pix_y;

    logic [TREE_LATENCY-1:0] p_valid, p_sof, p_last;
    logic [X_WIDTH-1:0]      p_x   [TREE_LATENCY];
    logic [Y_WIDTH-1:0]      p_y   [TREE_LATENCY];
    logic [SCORE_WIDTH-1:0]  p_thr [TREE_LATENCY];

    logic                   d_valid, d_sof, d_last;
    logic [X_WIDTH-1:0]     d_x;
    logic [Y_WIDTH-1:0]     d_y;
    logic [SCORE_WIDTH-1:0] d_thr;

    logic                   found, found_nxt, base_found;
    logic [SCORE_WIDTH-1:0] best_score, score_nxt, base_score, thr_reg, thr_use;
    logic [X_WIDTH-1:0]     best_x, x_nxt, base_x;
    logic [Y_WIDTH-1:0]     best_y, y_nxt, base_y;
    logic                   start, process, clear, eligible, upd;

    logic                   res_found_q;
    logic [SCORE_WIDTH-1:0] res_score_q;
    logic [X_WIDTH-1:0]     res_x_q;
    logic [Y_WIDTH-1:0]     res_y_q;

    // Stray pixels outside a frame (no sof seen yet) are kept out of the counters and pipeline.
    always_comb begin
        accept   = bus.pix_valid & (bus.sof | in_frame);
        pix_x    = bus.sof ? '0 : cnt_x;
        pix_y    = bus.sof ? '0 : cnt_y;
        pix_last = (pix_x == X_LAST) && (pix_y == Y_LAST);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            in_frame <= 1'b0;
            cnt_x    <= '0;
            cnt_y    <= '0;
        end else if (accept) begin
            in_frame <= !pix_last;
            if (pix_x == X_LAST) begin
                cnt_x <= '0;
                cnt_y <= (pix_y == Y_LAST) ? pix_y : pix_y + 1'b1;
            end else begin
                cnt_x <= pix_x + 1'b1;
                cnt_y <= pix_y;
            end
        end
    end

    // Threshold rides along with sof so it applies to exactly the frame it was sampled for.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            p_valid <= '0;
            p_sof   <= '0;
            p_last  <= '0;
            for (int i = 0; i < TREE_LATENCY; i++) begin
                p_x[i]   <= '0;
                p_y[i]   <= '0;
                p_thr[i] <= '0;
            end
        end else begin
            p_valid[0] <= accept;
            p_sof[0]   <= accept & bus.sof;
            p_last[0]  <= accept & pix_last;
            p_x[0]     <= pix_x;
            p_y[0]     <= pix_y;
            p_thr[0]   <= bus.thresh;
            for (int i = 1; i < TREE_LATENCY; i++) begin
                p_valid[i] <= p_valid[i-1];
                p_sof[i]   <= p_sof[i-1];
                p_last[i]  <= p_last[i-1];
                p_x[i]     <= p_x[i-1];
                p_y[i]     <= p_y[i-1];
                p_thr[i]   <= p_thr[i-1];
            end
        end
    end

    assign d_valid = p_valid[TREE_LATENCY-1];
    assign d_sof   = p_sof[TREE_LATENCY-1];
    assign d_last  = p_last[TREE_LATENCY-1];
    assign d_x     = p_x[TREE_LATENCY-1];
    assign d_y     = p_y[TREE_LATENCY-1];
    assign d_thr   = p_thr[TREE_LATENCY-1];

    // A delayed sof always (re)starts the frame from a clean best, whatever the state.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        process   = 1'b0;
        case (state)
            IDLE: begin
                if (d_valid && d_sof) begin
                    start     = 1'b1;
                    process   = 1'b1;
                    state_nxt = d_last ? REPORT : SCAN;
                end
            end
            SCAN: begin
                if (d_valid) begin
                    process = 1'b1;
                    start   = d_sof;
                    if (d_last) state_nxt = REPORT;
                end
            end
            REPORT: begin
                state_nxt = IDLE;
                if (d_valid && d_sof) begin
                    start     = 1'b1;
                    process   = 1'b1;
                    state_nxt = d_last ? REPORT : SCAN;
                end
            end
            default: state_nxt = IDLE;
        endcase

        clear      = start | (state == REPORT);
        thr_use    = start ? d_thr : thr_reg;
        base_found = clear ? 1'b0 : found;
        base_score = clear ? '0 : best_score;
        base_x     = clear ? '0 : best_x;
        base_y     = clear ? '0 : best_y;

        eligible = (d_x >= X_MIN) && (d_y >= Y_MIN);
        upd      = process && eligible && (bus.score >= thr_use) &&
                   (!base_found || (bus.score > base_score));

        found_nxt = upd | base_found;
        score_nxt = upd ? bus.score : base_score;
        x_nxt     = upd ? d_x - X_MIN : base_x;
        y_nxt     = upd ? d_y - Y_MIN : base_y;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= IDLE;
            found       <= 1'b0;
            best_score  <= '0;
            best_x      <= '0;
            best_y      <= '0;
            thr_reg     <= '0;
            res_found_q <= 1'b0;
            res_score_q <= '0;
            res_x_q     <= '0;
            res_y_q     <= '0;
        end else begin
            state      <= state_nxt;
            found      <= found_nxt;
            best_score <= score_nxt;
            best_x     <= x_nxt;
            best_y     <= y_nxt;
            if (start) thr_reg <= d_thr;
            if (state_nxt == REPORT) begin
                res_found_q <= found_nxt;
                res_score_q <= score_nxt;
                res_x_q     <= x_nxt;
                res_y_q     <= y_nxt;
            end
        end
    end

    assign bus.busy      = (state == SCAN);
    assign bus.res_valid = (state == REPORT);
    assign bus.res_found = res_found_q;
    assign bus.res_score = res_score_q;
    assign bus.res_x     = res_x_q;
    assign bus.res_y     = res_y_q;
endmodule

// File: tb/tb_match_peak_tracker.sv
// Scoreboard bench for match_peak_tracker on a tiny 8x6 frame with a 3x3
// template and a modelled 2-cycle adder tree.
module tb_match_peak_tracker;
    localparam int TS = 3;
    localparam int SW = 4;
    localparam int TL = 2;
    localparam int H  = 8;
    localparam int V  = 6;
    localparam int XW = 3;
    localparam int YW = 3;

    typedef struct {
        int found;
        int x;
        int y;
        int score;
        int cyc;
    } exp_t;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    match_peak_tracker_if #(.SCORE_WIDTH(SW), .X_WIDTH(XW), .Y_WIDTH(YW)) bus ();

    match_peak_tracker #(
        .TEMPL_SIZE(TS), .SCORE_WIDTH(SW), .TREE_LATENCY(TL),
        .H_ACTIVE(H), .V_ACTIVE(V), .X_WIDTH(XW), .Y_WIDTH(YW)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    int   busy_lo = 1 << 30;
    int   busy_hi = 0;
    int   last_cyc = 0;
    int   score_map [V][H];
    exp_t expq [$];
    exp_t last_exp;

    logic [SW-1:0] tree_in = '0;
    logic [SW-1:0] tree_dl [TL];

    always @(posedge clk) cyc <= cyc + 1;

    // Adder-tree stand-in: the score for a pixel appears TL cycles after it.
    always @(posedge clk) begin
        tree_dl[0] <= tree_in;
        for (int i = 1; i < TL; i++) tree_dl[i] <= tree_dl[i-1];
    end
    assign bus.score = tree_dl[TL-1];

    task automatic checkOutput(input string name, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("[TB] FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    endtask

    function automatic exp_t refModel(input int thr);
        exp_t r;
        r.found = 0; r.x = 0; r.y = 0; r.score = 0; r.cyc = 0;
        for (int yy = TS - 1; yy < V; yy++)
            for (int xx = TS - 1; xx < H; xx++)
                if (score_map[yy][xx] >= thr && (r.found == 0 || score_map[yy][xx] > r.score)) begin
                    r.found = 1;
                    r.score = score_map[yy][xx];
                    r.x     = xx - (TS - 1);
                    r.y     = yy - (TS - 1);
                end
        return r;
    endfunction

    task automatic fillMap(input int val);
        for (int yy = 0; yy < V; yy++)
            for (int xx = 0; xx < H; xx++)
                score_map[yy][xx] = val;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            bus.pix_valid = 1'b0;
            bus.sof       = 1'b0;
            tree_in       = '0;
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"},      int'(bus.busy),      0);
        checkOutput({tag, "_res_valid"}, int'(bus.res_valid), 0);
        checkOutput({tag, "_res_found"}, int'(bus.res_found), 0);
        checkOutput({tag, "_res_x"},     int'(bus.res_x),     0);
        checkOutput({tag, "_res_y"},     int'(bus.res_y),     0);
        checkOutput({tag, "_res_score"}, int'(bus.res_score), 0);
    endtask

    task automatic holdCheck(input string tag);
        checkOutput({tag, "_hold_found"}, int'(bus.res_found), last_exp.found);
        checkOutput({tag, "_hold_x"},     int'(bus.res_x),     last_exp.x);
        checkOutput({tag, "_hold_y"},     int'(bus.res_y),     last_exp.y);
        checkOutput({tag, "_hold_score"}, int'(bus.res_score), last_exp.score);
        checkOutput({tag, "_busy_idle"},  int'(bus.busy),      0);
    endtask

    // Drives one raster frame from score_map; abort_at stops before that pixel,
    // rst_at pulses nrst while that pixel is on the bus.
    task automatic applyStimulus(input int thr, input int gap, input int abort_at, input int rst_at);
        exp_t e;
        bit   complete;
        complete = (abort_at < 0) && (rst_at < 0);
        for (int i = 0; i < H * V; i++) begin
            int px;
            int py;
            px = i % H;
            py = i / H;
            if (i == abort_at) return;
            @(posedge clk); #1;
            bus.pix_valid = 1'b1;
            bus.sof       = (i == 0);
            bus.thresh    = (i == 0) ? SW'(thr) : SW'($urandom_range(0, 15));
            tree_in       = SW'(score_map[py][px]);
            last_cyc      = cyc;
            if (i == 0 && complete) begin
                busy_lo = cyc + TL + 1;
                busy_hi = 1 << 30;
            end
            if (i == rst_at) begin
                #2;
                nrst          = 1'b0;
                bus.pix_valid = 1'b0;
                #1;
                checkAllZero("midframe_rst");
                @(posedge clk); #1;
                nrst = 1'b1;
                #1;
                checkAllZero("after_rst");
            end
            if (px == H - 1 && i != H * V - 1) idleCycles(gap);
        end
        if (complete) begin
            e       = refModel(thr);
            e.cyc   = last_cyc + TL + 1;
            busy_hi = last_cyc + TL;
            expq.push_back(e);
        end
    endtask

    // Monitor: every result strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (nrst && bus.res_valid) begin
            if (expq.size() == 0) begin
                checkOutput("unexpected_res_valid", 1, 0);
            end else begin
                e = expq.pop_front();
                checkOutput("res_latency_cycle", cyc, e.cyc);
                checkOutput("res_found", int'(bus.res_found), e.found);
                checkOutput("res_x",     int'(bus.res_x),     e.x);
                checkOutput("res_y",     int'(bus.res_y),     e.y);
                checkOutput("res_score", int'(bus.res_score), e.score);
                last_exp = e;
            end
        end
        if (nrst && cyc >= busy_lo && cyc <= busy_hi)
            checkOutput("busy_in_frame", int'(bus.busy), 1);
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", passes, checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.pix_valid = 1'b0;
        bus.sof       = 1'b0;
        bus.thresh    = '0;
        last_exp      = '{0, 0, 0, 0, 0};
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");
        nrst = 1'b1;
        idleCycles(3);
        checkAllZero("post_reset");

        $display("[TB] single peak");
        fillMap(2);
        score_map[4][5] = 9;
        applyStimulus(5, 0, -1, -1);
        idleCycles(6);
        holdCheck("peak");

        $display("[TB] tie and partial-window edge");
        fillMap(1);
        score_map[2][2] = 7;
        score_map[3][6] = 7;
        score_map[5][1] = 15;
        applyStimulus(5, 0, -1, -1);
        idleCycles(6);
        holdCheck("tie");

        $display("[TB] below threshold");
        fillMap(4);
        applyStimulus(5, 0, -1, -1);
        idleCycles(6);
        holdCheck("below");

        $display("[TB] blanking gaps");
        fillMap(2);
        score_map[4][5] = 9;
        applyStimulus(5, 3, -1, -1);
        idleCycles(6);
        holdCheck("gaps");

        $display("[TB] early restart");
        fillMap(1);
        score_map[2][2] = 15;
        applyStimulus(5, 0, 3 + 2 * H, -1);
        fillMap(2);
        score_map[4][5] = 9;
        applyStimulus(5, 0, -1, -1);
        idleCycles(6);
        holdCheck("restart");

        $display("[TB] reset mid-frame");
        fillMap(2);
        score_map[4][5] = 11;
        applyStimulus(5, 0, -1, 4 + 4 * H);
        idleCycles(6);
        checkAllZero("rst_idle");
        fillMap(1);
        score_map[2][2] = 7;
        score_map[3][6] = 7;
        applyStimulus(5, 0, -1, -1);
        idleCycles(6);
        holdCheck("rst_next");

        $display("[TB] random frames");
        for (int f = 0; f < 6; f++) begin
            for (int yy = 0; yy < V; yy++)
                for (int xx = 0; xx < H; xx++)
                    score_map[yy][xx] = int'($urandom_range(0, 15));
            applyStimulus(int'($urandom_range(0, 15)), int'($urandom_range(0, 2)), -1, -1);
            if (f % 2 == 1) idleCycles(4);
        end
        idleCycles(8);
        holdCheck("random");

        checkOutput("pending_results", expq.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/match_peak_tracker.md
Name: match_peak_tracker

Overview:
- Sits directly downstream of the pipelined template adder tree in the camera template-matching path.
- Each cycle the tree emits the match score for the window that ended TREE_LATENCY cycles earlier. This block re-aligns pixel coordinates and valid/sof to that score.
- It scans the frame for the highest score that meets a threshold and reports the best window position once per frame.

Parameters:
- TEMPL_SIZE, 64, template side in pixels; window is TEMPL_SIZE x TEMPL_SIZE.
- SCORE_WIDTH, 13, score width; equals adder-tree output width (1 + clog2(TEMPL_SIZE^2)).
- TREE_LATENCY, 12, cycles from a pixel's pix_valid to its score at the score input.
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- X_WIDTH, 10, horizontal coordinate width.
- Y_WIDTH, 9, vertical coordinate width.

Ports:
- clk  in  1  system clock
- nrst  in  1  reset
- pix_valid  in  1  window advanced by one pixel this cycle (same cycle the tree samples it)
- sof  in  1  qualifies pix_valid; marks the first pixel of a frame
- score  in  SCORE_WIDTH  adder-tree sum, valid TREE_LATENCY cycles after the matching pix_valid
- thresh  in  SCORE_WIDTH  minimum acceptable score; sampled at sof
- busy  out  1  high in SCAN state
- res_valid  out  1  one-cycle result strobe
- res_found  out  1  a score >= thresh occurred in the frame
- res_x  out  X_WIDTH  best window top-left x
- res_y  out  Y_WIDTH  best window top-left y
- res_score  out  SCORE_WIDTH  best score (0 if not found)

Behaviour:
- Interface: one clock, clk. Reset nrst is asynchronous, active-low. All flops clear on nrst low.
- Reset values: busy, res_valid, res_found = 0; res_x, res_y, res_score = 0.
- Input side:
  - x/y counters advance on pix_valid.
  - pix_valid & sof loads x=0, y=0.
  - Otherwise x increments; at x = H_ACTIVE-1, x wraps to 0 and y increments.
  - y saturates at V_ACTIVE-1.
- Alignment:
  - pix_valid, sof, x, y and last flag pass through a TREE_LATENCY-deep shift register, giving d_valid, d_sof, d_x, d_y, d_last.
  - last = (x==H_ACTIVE-1 && y==V_ACTIVE-1).
  - score is consumed only when d_valid=1.
- Window qualification: a score is eligible when d_x >= TEMPL_SIZE-1 and d_y >= TEMPL_SIZE-1. Scores for partial windows at the left/top edge are ignored.
- Candidate position: cand_x = d_x-(TEMPL_SIZE-1), cand_y = d_y-(TEMPL_SIZE-1).
- Update rule: when eligible and score >= thr_reg and (!found or score > best_score), latch best_score, best_x, best_y and set found.
  - The comparison is strict, so a tie keeps the earliest window in raster order.
- FSM, states IDLE, SCAN, REPORT:
  - IDLE: pix_valid without sof is ignored by counters and pipeline. d_valid & d_sof goes to SCAN; thr_reg was captured at the input sof. That first pixel is processed in the same cycle.
  - SCAN: busy=1. d_valid & d_last goes to REPORT.
  - SCAN: d_valid & d_sof again (frame restarted early) abandons the current frame with no res_valid. best/found clear and thr_reg reloads. Processing restarts with this pixel; state stays SCAN.
  - REPORT (one cycle): res_valid=1 and res_* are driven from best_*. best/found clear. Next state is IDLE. If d_valid & d_sof occurs in this cycle, go to SCAN and process that pixel.
- res_x, res_y, res_score, res_found hold their values until the next REPORT.
- Latency: res_valid rises TREE_LATENCY+1 clocks after the pix_valid of the frame's last pixel.
- Gaps: pix_valid may be low for any number of cycles (blanking). Counters and the FSM hold.
- Async nrst mid-frame: everything returns to reset values and IDLE. The next sof starts cleanly.

Test Plan:
- Small config for all tests: TEMPL_SIZE=3, H_ACTIVE=8, V_ACTIVE=6, TREE_LATENCY=2, SCORE_WIDTH=4, thresh=5.
- Single peak: continuous frame; model score = 9 for the window ending at (x=5,y=4), 2 elsewhere -> res_valid exactly 3 cycles after the last pix_valid; res_found=1, res_x=3, res_y=2, res_score=9.
- Tie and edge: score 7 at window ends (2,2) and (6,3); score 15 at (1,5), which is a partial window -> res_x=0, res_y=0, res_score=7; the 15 is ignored.
- Below threshold: all scores 4 -> res_valid=1, res_found=0, res_score=0; the previous frame's result is overwritten.
- Blanking gaps: same as test 1 with pix_valid low for 3 cycles at every line end -> identical result; busy stays high throughout the frame.
- Early restart and reset: sof reasserted at pixel (3,2) -> no res_valid for the aborted frame; the next full frame reports normally. Separately, drop nrst low at pixel (4,4) for one cycle -> all outputs 0, state IDLE, no strobe until the next complete frame.
